// File: rtl/entry_lock_ctrl.sv
// Keypad entry controller: accepts key edges, streams digits into the user-input or
// stored-passcode shift arrays, and runs the unlock / reprogram / lockout sequencing.
module entry_lock_ctrl #(
    parameter int CODE_LEN      = 8,
    parameter int MAX_FAIL      = 3,
    parameter int UNLOCK_CYCLES = 500,
    parameter int LOCK_CYCLES   = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       prog_en,
    input  logic       abort,
    input  logic       comp_eq,
    output logic [3:0] digit_out,
    output logic       ui_shift,
    output logic       sp_shift,
    output logic       unlocked,
    output logic       alarm,
    output logic       err,
    output logic       prog_done,
    output logic [3:0] digit_cnt,
    output logic [1:0] fail_cnt,
    output logic [2:0] state_dbg
);

    localparam int HOLD_MAX = (UNLOCK_CYCLES > LOCK_CYCLES) ? UNLOCK_CYCLES : LOCK_CYCLES;
    localparam int TW       = $clog2(HOLD_MAX + 1);

    localparam logic [TW-1:0] UNLOCK_LOAD = TW'(UNLOCK_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LOAD   = TW'(LOCK_CYCLES - 1);
    localparam logic [3:0]    LAST_DIGIT  = 4'(CODE_LEN);
    localparam logic [2:0]    FAIL_LIMIT  = 3'(MAX_FAIL);
    localparam logic [1:0]    FAIL_SAT    = 2'(MAX_FAIL);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTER   = 3'd1,
        S_COMPARE = 3'd2,
        S_UNLOCK  = 3'd3,
        S_PROGRAM = 3'd4,
        S_LOCKOUT = 3'd5
    } state_t;

    state_t        r_state;
    logic          r_key_prev;
    logic [3:0]    r_digit_out;
    logic          r_ui_shift;
    logic          r_sp_shift;
    logic          r_err;
    logic          r_prog_done;
    logic [3:0]    r_digit_cnt;
    logic [1:0]    r_fail_cnt;
    logic [TW-1:0] r_timer;

    state_t        w_state_nx;
    logic [3:0]    w_digit_nx;
    logic          w_ui_nx;
    logic          w_sp_nx;
    logic          w_err_nx;
    logic          w_done_nx;
    logic [3:0]    w_cnt_nx;
    logic [1:0]    w_fail_nx;
    logic [TW-1:0] w_timer_nx;
    logic          w_key_acc;
    logic [3:0]    w_cnt_inc;
    logic [2:0]    w_fail_inc;
    logic          w_last_strobe;

    assign w_key_acc     = key_valid & ~r_key_prev;
    assign w_cnt_inc     = r_digit_cnt + 4'd1;
    assign w_fail_inc    = {1'b0, r_fail_cnt} + 3'd1;
    assign w_last_strobe = (r_ui_shift | r_sp_shift) && (r_digit_cnt == LAST_DIGIT);

    always_comb begin
        w_state_nx = r_state;
        w_digit_nx = r_digit_out;
        w_ui_nx    = 1'b0;
        w_sp_nx    = 1'b0;
        w_err_nx   = 1'b0;
        w_done_nx  = 1'b0;
        w_cnt_nx   = r_digit_cnt;
        w_fail_nx  = r_fail_cnt;
        w_timer_nx = r_timer;
        case (r_state)
            S_IDLE: begin
                if (w_key_acc) begin
                    w_state_nx = S_ENTER;
                    w_digit_nx = key_digit;
                    w_ui_nx    = 1'b1;
                    w_cnt_nx   = 4'd1;
                end
            end
            S_ENTER: begin
                // Abort wins over both the final-digit handoff and a same-cycle key.
                if (abort) begin
                    w_state_nx = S_IDLE;
                    w_cnt_nx   = 4'd0;
                end else if (w_last_strobe) begin
                    w_state_nx = S_COMPARE;
                end else if (w_key_acc) begin
                    w_digit_nx = key_digit;
                    w_ui_nx    = 1'b1;
                    w_cnt_nx   = w_cnt_inc;
                end
            end
            S_COMPARE: begin
                w_cnt_nx = 4'd0;
                if (comp_eq) begin
                    w_state_nx = S_UNLOCK;
                    w_fail_nx  = 2'd0;
                    w_timer_nx = UNLOCK_LOAD;
                end else if (w_fail_inc < FAIL_LIMIT) begin
                    w_state_nx = S_IDLE;
                    w_fail_nx  = w_fail_inc[1:0];
                    w_err_nx   = 1'b1;
                end else begin
                    w_state_nx = S_LOCKOUT;
                    w_fail_nx  = FAIL_SAT;
                    w_timer_nx = LOCK_LOAD;
                end
            end
            S_UNLOCK: begin
                if (w_key_acc && prog_en) begin
                    w_state_nx = S_PROGRAM;
                    w_digit_nx = key_digit;
                    w_sp_nx    = 1'b1;
                    w_cnt_nx   = 4'd1;
                end else if (r_timer == '0) begin
                    w_state_nx = S_IDLE;
                end else begin
                    w_timer_nx = r_timer - 1'b1;
                end
            end
            S_PROGRAM: begin
                if (abort) begin
                    w_state_nx = S_IDLE;
                    w_cnt_nx   = 4'd0;
                end else if (w_last_strobe) begin
                    w_state_nx = S_IDLE;
                    w_done_nx  = 1'b1;
                    w_cnt_nx   = 4'd0;
                end else if (w_key_acc) begin
                    w_digit_nx = key_digit;
                    w_sp_nx    = 1'b1;
                    w_cnt_nx   = w_cnt_inc;
                end
            end
            S_LOCKOUT: begin
                if (r_timer == '0) begin
                    w_state_nx = S_IDLE;
                    w_fail_nx  = 2'd0;
                end else begin
                    w_timer_nx = r_timer - 1'b1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // key_prev resets high so a key held through reset never registers as an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_key_prev  <= 1'b1;
            r_digit_out <= 4'd0;
            r_ui_shift  <= 1'b0;
            r_sp_shift  <= 1'b0;
            r_err       <= 1'b0;
            r_prog_done <= 1'b0;
            r_digit_cnt <= 4'd0;
            r_fail_cnt  <= 2'd0;
            r_timer     <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_key_prev  <= key_valid;
            r_digit_out <= w_digit_nx;
            r_ui_shift  <= w_ui_nx;
            r_sp_shift  <= w_sp_nx;
            r_err       <= w_err_nx;
            r_prog_done <= w_done_nx;
            r_digit_cnt <= w_cnt_nx;
            r_fail_cnt  <= w_fail_nx;
            r_timer     <= w_timer_nx;
        end
    end

    assign digit_out = r_digit_out;
    assign ui_shift  = r_ui_shift;
    assign sp_shift  = r_sp_shift;
    assign unlocked  = (r_state == S_UNLOCK) || (r_state == S_PROGRAM);
    assign alarm     = (r_state == S_LOCKOUT);
    assign err       = r_err;
    assign prog_done = r_prog_done;
    assign digit_cnt = r_digit_cnt;
    assign fail_cnt  = r_fail_cnt;
    assign state_dbg = r_state;

endmodule

// File: tb/tb_entry_lock_ctrl.sv
// Bench for entry_lock_ctrl: table of code entries plus hand sequences for reprogram,
// abort, held keys and mid-operation reset; strobes are checked against an expected queue.
module tb_entry_lock_ctrl;

    localparam int W = 9;
    localparam int UNLOCK_CYCLES = 500;
    localparam int LOCK_CYCLES   = 1000;
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ENTER   = 3'd1;
    localparam logic [2:0] ST_COMPARE = 3'd2;
    localparam logic [2:0] ST_UNLOCK  = 3'd3;
    localparam logic [2:0] ST_PROGRAM = 3'd4;
    localparam logic [2:0] ST_LOCKOUT = 3'd5;
    localparam logic [31:0] GOOD_CODE = 32'h21935488;

    typedef struct {
        logic [31:0] code;
        logic        eq;
        logic [2:0]  exp_state;
        logic [1:0]  exp_fail;
        logic        exp_err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       prog_en;
    logic       abort;
    logic       comp_eq;
    logic [3:0] digit_out;
    logic       ui_shift;
    logic       sp_shift;
    logic       unlocked;
    logic       alarm;
    logic       err;
    logic       prog_done;
    logic [3:0] digit_cnt;
    logic [1:0] fail_cnt;
    logic [2:0] state_dbg;

    int n_checks = 0;
    int n_errors = 0;
    int ui_cnt = 0;
    int sp_cnt = 0;
    int done_cnt = 0;
    int unl_cycles = 0;
    int alarm_cycles = 0;
    logic [W-1:0] exp_q[$];
    vec_t vecs[6];

    entry_lock_ctrl #(
        .CODE_LEN(8), .MAX_FAIL(3), .UNLOCK_CYCLES(UNLOCK_CYCLES), .LOCK_CYCLES(LOCK_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_digit(key_digit),
        .prog_en(prog_en), .abort(abort), .comp_eq(comp_eq),
        .digit_out(digit_out), .ui_shift(ui_shift), .sp_shift(sp_shift),
        .unlocked(unlocked), .alarm(alarm), .err(err), .prog_done(prog_done),
        .digit_cnt(digit_cnt), .fail_cnt(fail_cnt), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got time limit reached, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor/scoreboard: every strobe must match the head of the expected queue.
    always @(negedge clk) begin
        logic [W-1:0] e;
        check("strobe_exclusive", {31'd0, ui_shift & sp_shift}, 32'd0);
        if (ui_shift || sp_shift) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_strobe: got ui=%0b sp=%0b digit=%0h cnt=%0d required none",
                         ui_shift, sp_shift, digit_out, digit_cnt);
            end else begin
                e = exp_q.pop_front();
                check("strobe", {23'd0, sp_shift, digit_out, digit_cnt}, {23'd0, e});
            end
        end
        if (ui_shift)  ui_cnt++;
        if (sp_shift)  sp_cnt++;
        if (prog_done) done_cnt++;
        if (unlocked)  unl_cycles++;
        if (alarm)     alarm_cycles++;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic press_key(input logic [3:0] d, input bit expect_acc, input bit sel,
                             input logic [3:0] cnt);
        if (expect_acc) exp_q.push_back({sel, d, cnt});
        key_digit = d;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        step();
    endtask

    task automatic enter_code(input logic [31:0] code);
        for (int i = 0; i < 8; i++) begin
            press_key(code[31-4*i -: 4], 1'b1, 1'b0, 4'(i + 1));
        end
    endtask

    task automatic wait_state(input logic [2:0] target, input int budget, input string name);
        int n = 0;
        while (state_dbg !== target && n < budget) begin
            step();
            n++;
        end
        check(name, {29'd0, state_dbg}, {29'd0, target});
    endtask

    task automatic check_zero(input string name);
        check(name, {13'd0, digit_out, ui_shift, sp_shift, unlocked, alarm, err, prog_done,
                     digit_cnt, fail_cnt, state_dbg}, 32'd0);
    endtask

    initial begin
        int u0, a0, ui0, sp0, d0;
        rst = 1'b1; key_valid = 1'b0; key_digit = 4'd0;
        prog_en = 1'b0; abort = 1'b0; comp_eq = 1'b0;
        vecs[0] = '{GOOD_CODE,    1'b1, ST_UNLOCK,  2'd0, 1'b0};
        vecs[1] = '{32'h11111111, 1'b0, ST_IDLE,    2'd1, 1'b1};
        vecs[2] = '{GOOD_CODE,    1'b1, ST_UNLOCK,  2'd0, 1'b0};
        vecs[3] = '{32'h90817263, 1'b0, ST_IDLE,    2'd1, 1'b1};
        vecs[4] = '{32'h45454545, 1'b0, ST_IDLE,    2'd2, 1'b1};
        vecs[5] = '{32'h00009999, 1'b0, ST_LOCKOUT, 2'd3, 1'b0};
        step(); step();
        check_zero("reset_state");
        rst = 1'b0;
        step();

        for (int i = 0; i < 6; i++) begin
            u0 = unl_cycles; a0 = alarm_cycles;
            comp_eq = vecs[i].eq;
            enter_code(vecs[i].code);
            check($sformatf("v%0d_compare", i), {29'd0, state_dbg}, {29'd0, ST_COMPARE});
            step();
            check($sformatf("v%0d_state", i), {29'd0, state_dbg}, {29'd0, vecs[i].exp_state});
            check($sformatf("v%0d_fail", i), {30'd0, fail_cnt}, {30'd0, vecs[i].exp_fail});
            check($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
            check($sformatf("v%0d_cnt_clr", i), {28'd0, digit_cnt}, 32'd0);
            comp_eq = 1'b0;
            if (vecs[i].exp_state == ST_UNLOCK) begin
                press_key(4'($urandom_range(0, 9)), 1'b0, 1'b0, 4'd0);
                press_key(4'($urandom_range(0, 9)), 1'b0, 1'b0, 4'd0);
                abort = 1'b1;
                step();
                abort = 1'b0;
                wait_state(ST_IDLE, 700, $sformatf("v%0d_unlock_end", i));
                check($sformatf("v%0d_unlock_len", i), unl_cycles - u0, UNLOCK_CYCLES);
            end else if (vecs[i].exp_state == ST_LOCKOUT) begin
                ui0 = ui_cnt;
                for (int k = 0; k < 4; k++) press_key(4'($urandom_range(0, 9)), 1'b0, 1'b0, 4'd0);
                wait_state(ST_IDLE, 1200, $sformatf("v%0d_lock_end", i));
                check($sformatf("v%0d_alarm_len", i), alarm_cycles - a0, LOCK_CYCLES);
                check($sformatf("v%0d_fail_clr", i), {30'd0, fail_cnt}, 32'd0);
                check($sformatf("v%0d_lock_keys", i), ui_cnt - ui0, 32'd0);
            end
        end

        // Reprogram from UNLOCK.
        comp_eq = 1'b1;
        enter_code(GOOD_CODE);
        step();
        check("prog_unlock", {29'd0, state_dbg}, {29'd0, ST_UNLOCK});
        comp_eq = 1'b0;
        prog_en = 1'b1;
        ui0 = ui_cnt; sp0 = sp_cnt; d0 = done_cnt;
        for (int i = 0; i < 8; i++) begin
            press_key(4'($urandom_range(0, 9)), 1'b1, 1'b1, 4'(i + 1));
            if (i == 0) begin
                check("prog_state", {29'd0, state_dbg}, {29'd0, ST_PROGRAM});
                check("prog_unlocked", {31'd0, unlocked}, 32'd1);
            end
        end
        check("prog_return", {29'd0, state_dbg}, {29'd0, ST_IDLE});
        check("prog_done_pulse", {31'd0, prog_done}, 32'd1);
        check("prog_cnt_clr", {28'd0, digit_cnt}, 32'd0);
        step();
        check("prog_done_width", {31'd0, prog_done}, 32'd0);
        check("prog_sp_count", sp_cnt - sp0, 32'd8);
        check("prog_ui_count", ui_cnt - ui0, 32'd0);
        check("prog_done_count", done_cnt - d0, 32'd1);
        prog_en = 1'b0;

        // Abort together with a 6th key edge.
        ui0 = ui_cnt;
        for (int i = 0; i < 5; i++) press_key(4'($urandom_range(0, 9)), 1'b1, 1'b0, 4'(i + 1));
        key_digit = 4'd7;
        key_valid = 1'b1;
        abort = 1'b1;
        step();
        key_valid = 1'b0;
        abort = 1'b0;
        check("abort_state", {29'd0, state_dbg}, {29'd0, ST_IDLE});
        check("abort_cnt", {28'd0, digit_cnt}, 32'd0);
        step();
        check("abort_strobes", ui_cnt - ui0, 32'd5);

        // Key held for 20 cycles gives one strobe.
        ui0 = ui_cnt;
        exp_q.push_back({1'b0, 4'd3, 4'd1});
        key_digit = 4'd3;
        key_valid = 1'b1;
        repeat (20) step();
        key_valid = 1'b0;
        step();
        check("held_strobes", ui_cnt - ui0, 32'd1);
        check("held_state", {29'd0, state_dbg}, {29'd0, ST_ENTER});
        check("held_cnt", {28'd0, digit_cnt}, 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("held_abort", {29'd0, state_dbg}, {29'd0, ST_IDLE});

        // Key held across reset is not accepted.
        ui0 = ui_cnt;
        rst = 1'b1;
        key_valid = 1'b1;
        step(); step();
        rst = 1'b0;
        repeat (10) step();
        key_valid = 1'b0;
        step();
        check("held_rst_strobes", ui_cnt - ui0, 32'd0);
        check("held_rst_state", {29'd0, state_dbg}, {29'd0, ST_IDLE});

        // Reset in ENTER at digit 4, with a failure on record.
        enter_code(32'h55555555);
        step();
        check("pre_rst_fail", {30'd0, fail_cnt}, 32'd1);
        for (int i = 0; i < 4; i++) press_key(4'($urandom_range(0, 9)), 1'b1, 1'b0, 4'(i + 1));
        check("pre_rst_cnt", {28'd0, digit_cnt}, 32'd4);
        rst = 1'b1;
        step();
        check_zero("rst_in_enter");
        rst = 1'b0;
        step();

        // Reset half-way through UNLOCK.
        comp_eq = 1'b1;
        enter_code(GOOD_CODE);
        step();
        comp_eq = 1'b0;
        repeat (249) step();
        check("mid_unlock_state", {29'd0, state_dbg}, {29'd0, ST_UNLOCK});
        rst = 1'b1;
        step();
        check_zero("rst_in_unlock");
        rst = 1'b0;
        step();
        check("post_rst_idle", {29'd0, state_dbg}, {29'd0, ST_IDLE});

        check("queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/entry_lock_ctrl.md
ENTRY_LOCK_CTRL -- requirements
Module: entry_lock_ctrl

Interface
REQ-001 The block SHALL have parameter CODE_LEN, default 8, giving the number of digits per code.
REQ-002 The block SHALL have parameter MAX_FAIL, default 3, giving the consecutive mismatches that trigger lockout.
REQ-003 The block SHALL have parameter UNLOCK_CYCLES, default 500, giving the unlock hold time in clocks.
REQ-004 The block SHALL have parameter LOCK_CYCLES, default 1000, giving the lockout hold time in clocks.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit, reset, synchronous and active-high.
REQ-007 The block SHALL have port key_valid, input, 1 bit, encoder valid bit (bit 4 of the encoder output).
REQ-008 The block SHALL have port key_digit, input, 4 bits, encoder BCD digit (bits 3:0).
REQ-009 The block SHALL have port prog_en, input, 1 bit, request to reprogram the stored passcode.
REQ-010 The block SHALL have port abort, input, 1 bit, cancels the entry in progress.
REQ-011 The block SHALL have port comp_eq, input, 1 bit, 32-bit equality result from the comparator.
REQ-012 The block SHALL have port digit_out, output, 4 bits, registered digit presented to the shift arrays.
REQ-013 The block SHALL have port ui_shift, output, 1 bit, one-cycle shift strobe for the user-input array.
REQ-014 The block SHALL have port sp_shift, output, 1 bit, one-cycle shift strobe for the stored-passcode array.
REQ-015 The block SHALL have port unlocked, output, 1 bit, high while in UNLOCK or PROGRAM.
REQ-016 The block SHALL have port alarm, output, 1 bit, high while in LOCKOUT.
REQ-017 The block SHALL have port err, output, 1 bit, one-cycle pulse on a non-lockout mismatch.
REQ-018 The block SHALL have port prog_done, output, 1 bit, one-cycle pulse when reprogramming completes.
REQ-019 The block SHALL have port digit_cnt, output, 4 bits, digits accepted in the current sequence.
REQ-020 The block SHALL have port fail_cnt, output, 2 bits, consecutive mismatch count.

Function
REQ-021 Key acceptance SHALL be on the rising edge of key_valid: key_valid=1 while the registered previous value key_prev=0; one digit per edge; key_digit SHALL be sampled in that same cycle.
REQ-022 The FSM SHALL have states IDLE, ENTER, COMPARE, UNLOCK, PROGRAM and LOCKOUT.
REQ-023 An accepted key SHALL load digit_out and assert the selected strobe in the next cycle (1-cycle latency), and SHALL increment digit_cnt in that same cycle.
REQ-024 IDLE -> ENTER on an accepted key; that key SHALL count as digit 1 and target ui_shift.
REQ-025 ENTER: keys target ui_shift; in the cycle the CODE_LEN-th strobe is asserted, the FSM SHALL go to COMPARE.
REQ-026 COMPARE SHALL last exactly 1 cycle, sample comp_eq in that cycle, and clear digit_cnt.
REQ-027 Match -> UNLOCK; fail_cnt SHALL be cleared to 0.
REQ-028 Mismatch with fail_cnt+1 < MAX_FAIL -> IDLE; fail_cnt SHALL increment and err SHALL pulse for 1 cycle.
REQ-029 Mismatch with fail_cnt+1 = MAX_FAIL -> LOCKOUT.
REQ-030 UNLOCK SHALL hold for UNLOCK_CYCLES cycles, then go to IDLE.
REQ-031 In UNLOCK, an accepted key with prog_en=1 SHALL go to PROGRAM; that key SHALL count as digit 1 and target sp_shift.
REQ-032 In UNLOCK, an accepted key with prog_en=0 SHALL be ignored.
REQ-033 PROGRAM: keys target sp_shift; on the CODE_LEN-th strobe the FSM SHALL pulse prog_done, clear digit_cnt and go to IDLE; the PROGRAM state SHALL have no timeout.
REQ-034 LOCKOUT SHALL hold for LOCK_CYCLES cycles, then clear fail_cnt to 0 and go to IDLE.
REQ-035 Keys SHALL be ignored in COMPARE and LOCKOUT; ignored keys SHALL produce no strobe and no count change.
REQ-036 abort=1 in ENTER or PROGRAM SHALL go to IDLE, clear digit_cnt, and suppress any strobe pending from a key accepted in the same cycle.
REQ-037 abort=1 in any other state SHALL be ignored, and the UNLOCK and LOCKOUT timers SHALL continue.
REQ-038 ui_shift and sp_shift SHALL never be high in the same cycle.
REQ-039 fail_cnt SHALL saturate at MAX_FAIL and SHALL never wrap.
REQ-040 The hold timer SHALL be sized to ceil(log2(max(UNLOCK_CYCLES, LOCK_CYCLES)+1)) bits.
REQ-041 The hold timer SHALL be loaded on entry to UNLOCK or LOCKOUT.

Reset
REQ-042 rst=1 SHALL, at the next clk edge and from any state, force IDLE and clear every output and counter, with digit_out=0 and all strobes and pulses 0.
REQ-043 rst=1 SHALL set key_prev=1, so a key held through reset is not accepted after reset releases.
REQ-044 rst=1 SHALL abort an entry or programming sequence mid-way; the shift arrays SHALL not be touched by this block.

Verification
REQ-045 Scenario "correct entry": reset, enter digits 2,1,9,3,5,4,8,8 with comp_eq=1 in COMPARE -> 8 ui_shift pulses, each with the matching digit_out; unlocked=1 for 500 cycles; fail_cnt=0.
REQ-046 Scenario "three mismatches": 3 full entries with comp_eq=0 -> err pulses after entries 1 and 2; fail_cnt 1, then 2; then alarm=1 for 1000 cycles; 4 keys pressed during LOCKOUT produce no ui_shift; fail_cnt=0 afterwards.
REQ-047 Scenario "reprogram": unlock, hold prog_en=1, enter 8 digits -> 8 sp_shift pulses, 0 ui_shift pulses, prog_done pulses once, FSM returns to IDLE.
REQ-048 Scenario "abort": 5 digits entered, then abort in the same cycle as a 6th key edge -> no 6th strobe, digit_cnt=0, FSM in IDLE.
REQ-049 Scenario "held key": key_valid held high for 20 cycles -> exactly 1 strobe; key_valid held high across reset -> 0 strobes after reset releases.
REQ-050 Scenario "reset mid-operation": rst=1 in ENTER at digit_cnt=4 and in UNLOCK at timer midpoint -> next cycle IDLE with all outputs 0.
